irrigation_controller: RTL and testbench

Sequencing controller for the irrigation datapath. It decides, every clock, whether the tank fill valve, the sprinkler (Bs) or the drip line (Vs) is on, based on the H/M/L level sensors, a soil-dryness input and a high-temperature input. It detects inconsistent sensors and pump faults, and exposes its state and per-state elapsed seconds for the LED matrix and 7-segment display logic. It runs on the 50 MHz system clock and is paced by the 1 Hz enable derived from the clock divider.

---
 rtl/irrigation_controller.sv | 149 ++++++++++++++
 tb/tb_irrigation_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_controller.sv
// Irrigation sequencing FSM: fill valve, sprinkler and drip control with sensor and pump-fault detection.
// Optional feature macro: COOLDOWN_EN adds an idle lockout state after each irrigation run.
module irrigation_controller #(
  parameter int SPRINKLE_TIME = 30,
  parameter int DRIP_TIME     = 60,
  parameter int FILL_TIMEOUT  = 120,
  parameter int ERR_HOLD      = 2,
  parameter int COOLDOWN_TIME = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Us,
  input  logic       Ts,
  output logic       Ve,
  output logic       Bs,
  output logic       Vs,
  output logic       Error,
  output logic [1:0] err_code,
  output logic [2:0] state,
  output logic [7:0] seconds
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_SPRINKLE = 3'd2,
    ST_DRIP     = 3'd3,
    ST_ERROR    = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_SENSOR = 2'b01,
    ERR_FILL   = 2'b10
  } err_t;

  // Timeouts fire on the tick that would complete the last second, so compare against N-1.
  localparam logic [7:0] SPRINKLE_LAST = 8'(SPRINKLE_TIME - 1);
  localparam logic [7:0] DRIP_LAST     = 8'(DRIP_TIME - 1);
  localparam logic [7:0] FILL_LAST     = 8'(FILL_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LAST     = 8'(ERR_HOLD - 1);
  localparam logic [7:0] COOL_LAST     = 8'(COOLDOWN_TIME - 1);

`ifdef COOLDOWN_EN
  localparam state_t RUN_END = ST_COOLDOWN;
`else
  localparam state_t RUN_END = ST_IDLE;
`endif

  state_t     state_q, state_d;
  err_t       err_q, err_d;
  logic [7:0] seconds_q;
  logic [7:0] hold_q, hold_d;
  logic       bad;

  assign bad = (H & ~M) | (M & ~L);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    hold_d  = hold_q;
    if (bad && state_q != ST_ERROR) begin
      state_d = ST_ERROR;
      err_d   = ERR_SENSOR;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!L)                   state_d = ST_FILL;
          else if (Us && M && !Ts)  state_d = ST_SPRINKLE;
          else if (Us)              state_d = ST_DRIP;
        end
        ST_FILL: begin
          if (H) begin
            state_d = ST_IDLE;
          end else if (tick && seconds_q == FILL_LAST) begin
            state_d = ST_ERROR;
            err_d   = ERR_FILL;
          end
        end
        ST_SPRINKLE: begin
          if (!L)                                           state_d = ST_FILL;
          else if (!M || Ts)                                state_d = ST_DRIP;
          else if (!Us || (tick && seconds_q == SPRINKLE_LAST)) state_d = RUN_END;
        end
        ST_DRIP: begin
          if (!L)                                       state_d = ST_FILL;
          else if (!Us || (tick && seconds_q == DRIP_LAST)) state_d = RUN_END;
        end
        ST_ERROR: begin
          // A fill timeout is sticky; only a sensor error can recover on its own.
          if (err_q == ERR_SENSOR) begin
            if (bad) begin
              hold_d = '0;
            end else if (tick) begin
              if (hold_q == HOLD_LAST) begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
                hold_d  = '0;
              end else begin
                hold_d = hold_q + 8'd1;
              end
            end
          end
        end
        ST_COOLDOWN: begin
          if (!L)                                     state_d = ST_FILL;
          else if (tick && seconds_q == COOL_LAST)    state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      err_q     <= ERR_NONE;
      hold_q    <= '0;
      seconds_q <= '0;
      Ve        <= 1'b0;
      Bs        <= 1'b0;
      Vs        <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      if (state_d != state_q)             seconds_q <= '0;
      else if (tick && seconds_q != 8'hFF) seconds_q <= seconds_q + 8'd1;
      Ve    <= (state_d == ST_FILL);
      Bs    <= (state_d == ST_SPRINKLE);
      Vs    <= (state_d == ST_DRIP);
      Error <= (state_d == ST_ERROR);
    end
  end

  assign state    = state_q;
  assign err_code = err_q;
  assign seconds  = seconds_q;

endmodule

// File: tb/tb_irrigation_controller.sv
// Self-checking bench for irrigation_controller: directed walk through the main scenarios,
// then randomized sensor/tick traffic compared cycle by cycle against a behavioural model.
module tb_irrigation_controller;

  localparam int SPRINKLE_TIME = 30;
  localparam int DRIP_TIME     = 60;
  localparam int FILL_TIMEOUT  = 120;
  localparam int ERR_HOLD      = 2;
  localparam int COOLDOWN_TIME = 10;

  logic       clock = 1'b0;
  logic       reset_n, tick, H, M, L, Us, Ts;
  logic       Ve, Bs, Vs, Error;
  logic [1:0] err_code;
  logic [2:0] state;
  logic [7:0] seconds;

  irrigation_controller #(
    .SPRINKLE_TIME(SPRINKLE_TIME), .DRIP_TIME(DRIP_TIME), .FILL_TIMEOUT(FILL_TIMEOUT),
    .ERR_HOLD(ERR_HOLD), .COOLDOWN_TIME(COOLDOWN_TIME)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .H(H), .M(M), .L(L), .Us(Us), .Ts(Ts),
    .Ve(Ve), .Bs(Bs), .Vs(Vs), .Error(Error), .err_code(err_code), .state(state),
    .seconds(seconds)
  );

  always #10 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model: 0 idle, 1 fill, 2 sprinkle, 3 drip, 4 error, 5 cooldown; err 1 sensor, 2 fill timeout.
  int m_state, m_sec, m_err, m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int run_end();
`ifdef COOLDOWN_EN
    return 5;
`else
    return 0;
`endif
  endfunction

  task automatic model_update();
    bit bad;
    int ns, ne, nh;
    if (!reset_n) begin
      m_state = 0; m_sec = 0; m_err = 0; m_hold = 0;
      return;
    end
    bad = (H && !M) || (M && !L);
    ns = m_state; ne = m_err; nh = m_hold;
    if (bad && m_state != 4) begin
      ns = 4; ne = 1; nh = 0;
    end else begin
      case (m_state)
        0: if (!L) ns = 1; else if (Us && M && !Ts) ns = 2; else if (Us) ns = 3;
        1: if (H) ns = 0; else if (tick && m_sec + 1 == FILL_TIMEOUT) begin ns = 4; ne = 2; end
        2: if (!L) ns = 1; else if (!M || Ts) ns = 3;
           else if (!Us || (tick && m_sec + 1 == SPRINKLE_TIME)) ns = run_end();
        3: if (!L) ns = 1; else if (!Us || (tick && m_sec + 1 == DRIP_TIME)) ns = run_end();
        4: if (m_err == 1) begin
             if (bad) nh = 0;
             else if (tick) begin
               nh = m_hold + 1;
               if (nh >= ERR_HOLD) begin ns = 0; ne = 0; nh = 0; end
             end
           end
        5: if (!L) ns = 1; else if (tick && m_sec + 1 == COOLDOWN_TIME) ns = 0;
        default: ns = 0;
      endcase
    end
    if (ns != m_state) m_sec = 0;
    else if (tick)     m_sec = (m_sec < 255) ? m_sec + 1 : 255;
    m_state = ns; m_err = ne; m_hold = nh;
  endtask

  // One clock: model and DUT both consume the inputs held across the edge, outputs checked 1 ns later.
  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    check("state",    state,    m_state);
    check("seconds",  seconds,  m_sec);
    check("err_code", err_code, m_err);
    check("Ve",       Ve,       m_state == 1);
    check("Bs",       Bs,       m_state == 2);
    check("Vs",       Vs,       m_state == 3);
    check("Error",    Error,    m_state == 4);
    check("onehot_outputs", 32'(Ve) + 32'(Bs) + 32'(Vs) <= 1, 1);
  endtask

  task automatic tick_step(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic set_level(input int lvl);
    {H, M, L} = (lvl == 0) ? 3'b000 : (lvl == 1) ? 3'b001 : (lvl == 2) ? 3'b011 : 3'b111;
  endtask

  initial begin
    int lvl;
    reset_n = 1'b0; tick = 1'b0; {H, M, L} = 3'b000; Us = 1'b0; Ts = 1'b0;
    step();
    check("reset_state", state, 0);
    check("reset_seconds", seconds, 0);
    reset_n = 1'b1;

    // Empty tank fills, refills stop once H is seen.
    step();
    check("fill_entry_state", state, 1);
    check("fill_entry_Ve", Ve, 1);
    set_level(1); step();
    set_level(2); step();
    set_level(3); step();
    check("fill_done_state", state, 0);
    check("fill_done_Ve", Ve, 0);

    // Full sprinkler run of SPRINKLE_TIME ticks.
    set_level(2); Us = 1'b1; Ts = 1'b0;
    step();
    check("sprinkle_Bs", Bs, 1);
    tick_step(SPRINKLE_TIME - 1);
    check("sprinkle_sec_before_last", seconds, SPRINKLE_TIME - 1);
    tick = 1'b1; step(); tick = 1'b0;
    check("sprinkle_end_state", state, run_end());
    check("sprinkle_end_Bs", Bs, 0);

`ifndef COOLDOWN_EN
    // Heat mid-run diverts to drip with a fresh seconds count.
    step();
    tick_step(5);
    check("sprinkle_sec5", seconds, 5);
    Ts = 1'b1; step();
    check("heat_Bs", Bs, 0);
    check("heat_Vs", Vs, 1);
    check("heat_seconds", seconds, 0);
    tick_step(DRIP_TIME - 1);
    tick = 1'b1; step(); tick = 1'b0;
    check("drip_end_state", state, 0);
    step();
    check("drip_restart_state", state, 3);
`endif

    // Sensor fault, interrupted recovery, then clean recovery after ERR_HOLD ticks.
    Us = 1'b0; {H, M, L} = 3'b101; step();
    check("sensor_err_Error", Error, 1);
    check("sensor_err_code", err_code, 1);
    set_level(2); step();
    tick_step(1);
    {H, M, L} = 3'b101; step();
    set_level(2);
    tick_step(ERR_HOLD - 1);
    check("hold_restart_state", state, 4);
    tick_step(1);
    check("sensor_recover_state", state, 0);
    check("sensor_recover_code", err_code, 0);

    // Pump fault: H never arrives.
    set_level(0); step();
    tick_step(FILL_TIMEOUT - 1);
    check("fill_sec_before_timeout", seconds, FILL_TIMEOUT - 1);
    tick_step(1);
    check("fill_timeout_code", err_code, 2);
    for (int k = 0; k < 8; k++) begin
      {H, M, L} = 3'($urandom_range(0, 7)); Us = 1'($urandom_range(0, 1));
      tick = 1'b1; step(); tick = 1'b0;
    end
    check("fill_fault_sticky", err_code, 2);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    check("fault_reset_state", state, 0);
    check("fault_reset_Error", Error, 0);

    // Randomized traffic: mostly consistent levels, occasional faults and resets.
    lvl = 3; Us = 1'b0; Ts = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 14) == 0) lvl = $urandom_range(0, 3);
      if ($urandom_range(0, 59) == 0) {H, M, L} = 3'($urandom_range(0, 7));
      else set_level(lvl);
      if ($urandom_range(0, 24) == 0) Us = ~Us;
      if ($urandom_range(0, 24) == 0) Ts = ~Ts;
      tick    = ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 799) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
